// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared types and constants for the RGB level controller
package rgb_pkg;

    localparam int LEVEL_WIDTH = 8;
    localparam int LEVEL_MAX   = (1 << LEVEL_WIDTH) - 1;

    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        FADE_RG = 2'd1,
        FADE_GB = 2'd2,
        FADE_BR = 2'd3
    } ctrl_state_t;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_R = 2'd0;
    localparam ch_idx_t CH_G = 2'd1;
    localparam ch_idx_t CH_B = 2'd2;

endpackage

// File: rtl/fade_tick_gen.sv
// rtl/fade_tick_gen.sv - fade prescaler, one tick every FADE_DIV enabled cycles
module fade_tick_gen #(
    parameter int FADE_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FADE_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && !clr && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/rgb_level_controller.sv
// rtl/rgb_level_controller.sv - encoder-driven RGB level registers with colour-wheel fade
module rgb_level_controller #(
    parameter int LEVEL_WIDTH = 8,
    parameter int STEP        = 1,
    parameter int FADE_DIV    = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step_up,
    input  logic                   step_dn,
    input  logic                   sel,
    input  logic                   mode_toggle,
    output logic [LEVEL_WIDTH-1:0] level0,
    output logic [LEVEL_WIDTH-1:0] level1,
    output logic [LEVEL_WIDTH-1:0] level2,
    output logic [1:0]             sel_ch,
    output logic                   fade_active
);

    import rgb_pkg::*;

    localparam logic [LEVEL_WIDTH-1:0] LVL_MAX = '1;
    localparam logic [LEVEL_WIDTH-1:0] STEP_V  = LEVEL_WIDTH'(STEP);

    ctrl_state_t            state_q, state_d;
    ch_idx_t                sel_q, sel_d;
    logic [LEVEL_WIDTH-1:0] lvl_q [3];
    logic [LEVEL_WIDTH-1:0] lvl_d [3];
    logic                   tick;
    logic                   in_fade;

    function automatic logic [LEVEL_WIDTH-1:0] sat_up(input logic [LEVEL_WIDTH-1:0] v);
        return (v > LVL_MAX - STEP_V) ? LVL_MAX : v + STEP_V;
    endfunction

    function automatic logic [LEVEL_WIDTH-1:0] sat_dn(input logic [LEVEL_WIDTH-1:0] v);
        return (v < STEP_V) ? '0 : v - STEP_V;
    endfunction

    assign in_fade = (state_q != MANUAL);

    // Prescaler stays cleared in MANUAL and restarts on every mode change.
    fade_tick_gen #(
        .FADE_DIV (FADE_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .en    (in_fade),
        .clr   (!in_fade || mode_toggle),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lvl_d   = lvl_q;
        case (state_q)
            MANUAL: begin
                if (mode_toggle) begin
                    state_d  = FADE_RG;
                    lvl_d[0] = LVL_MAX;
                    lvl_d[1] = '0;
                    lvl_d[2] = '0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (sel_q == ch_idx_t'(i)) begin
                            if (step_up && !step_dn) begin
                                lvl_d[i] = sat_up(lvl_q[i]);
                            end else if (step_dn && !step_up) begin
                                lvl_d[i] = sat_dn(lvl_q[i]);
                            end
                        end
                    end
                    if (sel) begin
                        sel_d = (sel_q == CH_B) ? CH_R : sel_q + 2'd1;
                    end
                end
            end
            FADE_RG: begin
                if (mode_toggle) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    lvl_d[0] = lvl_q[0] - 1'b1;
                    lvl_d[1] = lvl_q[1] + 1'b1;
                    if (lvl_q[1] == LVL_MAX - 1'b1) state_d = FADE_GB;
                end
            end
            FADE_GB: begin
                if (mode_toggle) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    lvl_d[1] = lvl_q[1] - 1'b1;
                    lvl_d[2] = lvl_q[2] + 1'b1;
                    if (lvl_q[2] == LVL_MAX - 1'b1) state_d = FADE_BR;
                end
            end
            FADE_BR: begin
                if (mode_toggle) begin
                    state_d = MANUAL;
                end else if (tick) begin
                    lvl_d[2] = lvl_q[2] - 1'b1;
                    lvl_d[0] = lvl_q[0] + 1'b1;
                    if (lvl_q[0] == LVL_MAX - 1'b1) state_d = FADE_RG;
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MANUAL;
            sel_q    <= CH_R;
            lvl_q[0] <= '0;
            lvl_q[1] <= '0;
            lvl_q[2] <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            lvl_q   <= lvl_d;
        end
    end

    assign level0      = lvl_q[0];
    assign level1      = lvl_q[1];
    assign level2      = lvl_q[2];
    assign sel_ch      = sel_q;
    assign fade_active = in_fade;

endmodule

// File: doc/rgb_level_controller.md
Name: rgb_level_controller

Overview:
- Controller that owns the three 8-bit PWM level registers of the RGB mixer.
- Sources its inputs from one shared rotary encoder and one debounced button pair, in place of three independent encoder paths.
- In MANUAL mode the encoder steps the currently selected channel. In FADE mode an internal scheduler sweeps a colour wheel (R→G→B→R) at a programmable rate.
- Outputs feed the existing per-channel pwm instances directly.

Parameters:
- LEVEL_WIDTH, 8, width of each level output; LEVEL_MAX = 2^LEVEL_WIDTH-1.
- STEP, 1, amount added or subtracted per manual encoder step.
- FADE_DIV, 1000, clock cycles per fade step; legal range ≥2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- step_up  input  1  single-cycle pulse, encoder clockwise detent.
- step_dn  input  1  single-cycle pulse, encoder counter-clockwise detent.
- sel  input  1  single-cycle pulse, advance selected channel.
- mode_toggle  input  1  single-cycle pulse, MANUAL↔FADE.
- level0  output  LEVEL_WIDTH  red PWM level.
- level1  output  LEVEL_WIDTH  green PWM level.
- level2  output  LEVEL_WIDTH  blue PWM level.
- sel_ch  output  2  selected channel index, 0..2.
- fade_active  output  1  high while in any FADE state.

Behaviour:
- Reset (reset=0, async):
  - level0/1/2=0, sel_ch=0, state=MANUAL, fade_active=0, prescaler=0.
  - Release is synchronous to clk; a reset asserted mid-fade returns to MANUAL with all levels 0.
- All outputs are registered. An input pulse sampled at edge N is visible on outputs after edge N (1-cycle latency).
- States: MANUAL, FADE_RG, FADE_GB, FADE_BR.
- MANUAL:
  - step_up only: level[sel_ch] = min(level+STEP, LEVEL_MAX), saturating, no wrap.
  - step_dn only: level[sel_ch] = max(level-STEP, 0), saturating, no wrap.
  - step_up and step_dn in the same cycle: no change.
  - sel: sel_ch 0→1→2→0.
  - sel together with a step: the step applies to the old sel_ch, and sel_ch advances on the same edge.
  - mode_toggle → FADE_RG. On the same edge load levels {LEVEL_MAX,0,0}, clear prescaler, set fade_active=1. Any step in that cycle is dropped.
- Prescaler:
  - Counts 0..FADE_DIV-1 in FADE states only; tick when count==FADE_DIV-1, then wraps to 0.
  - Held at 0 in MANUAL.
- FADE_RG, per tick: level0 -= 1, level1 += 1. When the update makes level1==LEVEL_MAX, go to FADE_GB.
- FADE_GB, per tick: level1 -= 1, level2 += 1. At level2==LEVEL_MAX, go to FADE_BR.
- FADE_BR, per tick: level2 -= 1, level0 += 1. At level0==LEVEL_MAX, go to FADE_RG.
- Fade invariants:
  - level0+level1+level2 == LEVEL_MAX at every cycle in FADE.
  - One full wheel takes 3·LEVEL_MAX·FADE_DIV cycles.
- In FADE:
  - step_up, step_dn and sel are ignored; sel_ch holds.
  - mode_toggle → MANUAL, levels frozen at current values, prescaler cleared, fade_active=0.
  - mode_toggle on a tick cycle: the toggle wins and no fade step is applied.
- Inputs are assumed already synchronised/debounced and decoded to pulses upstream. Pulses wider than one cycle count once per cycle high.

Decomposition:
- Package rgb_pkg:
  - LEVEL_WIDTH, LEVEL_MAX constants.
  - ctrl_state_t enum {MANUAL, FADE_RG, FADE_GB, FADE_BR}.
  - ch_idx_t (2-bit) with CH_R=0, CH_G=1, CH_B=2.
- Sub-module fade_tick_gen (prescaler with enable and sync clear, outputs tick). Parameter FADE_DIV.
- Saturating add/sub stays inline in the controller.

Test Plan:
- Reset then three step_up pulses → level0=3, level1=level2=0, sel_ch=0. Then one sel and two step_up → level1=2, sel_ch=1.
- Saturation:
  - Force level0=254, apply step_up ×3 → level0 holds at 255.
  - From level2=1, apply step_dn ×2 → level2=0.
- Simultaneous events:
  - step_up+step_dn same cycle → no change.
  - sel+step_up with sel_ch=2 → level2 increments and sel_ch=0.
- Fade sweep (FADE_DIV=4): mode_toggle → next cycle {255,0,0}, fade_active=1.
  - After 4 cycles → {254,1,0}.
  - After 255 ticks → {0,255,0}, state FADE_GB.
  - After 765 ticks total → {255,0,0} in FADE_RG. Sum==255 checked every cycle.
- Fade exit/ignore: in FADE_GB, step_up/sel are ignored. mode_toggle coinciding with a tick → levels unchanged that cycle, fade_active=0. Subsequent step_up edits channel sel_ch.
- Async reset mid-fade: assert reset=0 between clock edges → outputs go to 0 and MANUAL immediately, without a clock edge. After release, the first tick does not occur.
